hilo_muldiv_ctrl: RTL
=====================

# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer that owns the architectural HI/LO register pair. It executes mult, multu, madd, maddu, div, divu, mthi and mtlo issued by the pipeline control, holding `busy` so the pipeline stalls HI/LO consumers. It replaces purely combinational HI/LO updates with properly clocked, 64-bit-correct accumulation.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width. The iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  issue request; accepted only when `busy`=0 and `flush`=0.
- `op`  in  3  operation: 0 mult, 1 multu, 2 madd, 3 maddu, 4 div, 5 divu, 6 mthi, 7 mtlo.
- `A`  in  WIDTH  rs operand; sampled at acceptance.
- `B`  in  WIDTH  rt operand; sampled at acceptance.
- `flush`  in  1  aborts the in-flight operation.
- `busy`  out  1  high while an iterative operation is in flight.
- `done`  out  1  one-cycle completion pulse.
- `div_by_zero`  out  1  pulses together with `done` for div/divu with `B`=0.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- FSM states: IDLE, MUL, DIV, COMMIT.
- IDLE + accept:
  - mult/multu/madd/maddu go to MUL.
  - div/divu with `B`≠0 go to DIV.
  - div/divu with `B`=0 go to COMMIT with no HI/LO write.
  - mthi/mtlo write `hi`/`lo`=`A` directly and stay in IDLE.
- Signed ops latch `|A|`, `|B|` and sign bits. Unsigned ops latch raw operands.
- MUL runs a shift-add, 1 bit per cycle, `WIDTH` cycles, into a 2·WIDTH product register. DIV runs a restoring divide, 1 bit per cycle, `WIDTH` cycles.
- COMMIT applies sign fix-up and writes the result, then returns to IDLE:
  - Product is negated if signA^signB.
  - Quotient is negated if signA^signB. Remainder takes the sign of A.
  - mult/multu: {hi,lo} = product.
  - madd/maddu: {hi,lo} = {hi,lo} + product, full 2·WIDTH add with carry from lo into hi. Product is sign-extended for madd and zero-extended for maddu. Overflow wraps modulo 2^(2·WIDTH).
  - div/divu: lo = quotient, hi = remainder.
  - Divide by zero: hi/lo unchanged, `div_by_zero`=1.
  - Signed -2^(WIDTH-1) / -1: lo=0x80000000, hi=0, no flag.
- `start` while `busy`=1 is ignored and not queued.
- `flush` in MUL/DIV/COMMIT: next state IDLE, no `done`, hi/lo unchanged.
- `flush` and `start` together in IDLE: `flush` wins and nothing is accepted.
- `rst` (async): state IDLE; `busy`, `done`, `div_by_zero`, `hi`, `lo` and all internal registers are 0.

## Timing
- E0 is the accepting edge.
- mul/div: `busy`=1 from after E0. Iteration edges are E1..E`WIDTH`. E`WIDTH`+1 performs COMMIT; after it `done`=1 and `busy`=0. Latency is 33 cycles at WIDTH=32.
- Divide by zero: COMMIT at E1, so `done`=`div_by_zero`=1 after E1, with `busy` high for 1 cycle.
- mthi/mtlo: hi/lo updated at E0, `done`=1 after E0, `busy` never asserted.
- A new `start` is accepted in the cycle `done` is high, which gives back-to-back issue.
- `hi`/`lo` change only at COMMIT or at mthi/mtlo edges and are stable otherwise.

## Configuration
- `MULDIV_DIV_EN` defined: the divider datapath and the DIV state are built as specified.
- `MULDIV_DIV_EN` undefined: there is no divider logic.
  - div/divu are accepted and complete like mthi/mtlo: hi/lo unchanged, `done`=1 after E0, `busy` never asserted.
  - `div_by_zero` is tied to 0.

## Test plan
- mult A=0xFFFFFFFE, B=3 -> `done` 33 cycles after accept, hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- mthi 0, mtlo 0xFFFFFFFF, then maddu A=1, B=1 -> hi=0x00000001, lo=0x00000000 (carry propagated). madd A=-1, B=1 from hi=lo=0 -> hi=lo=0xFFFFFFFF.
- div A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu A=7, B=2 -> lo=3, hi=1. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu A=7, B=0 after mthi 5 -> `done` and `div_by_zero` high 1 cycle after E1, hi=5, lo unchanged. Without `MULDIV_DIV_EN` -> `done` after E0, flag 0.
- start mult, pulse `start` at cycle 5, `flush` at cycle 10 -> no `done`, hi/lo unchanged, `busy`=0 next cycle, the cycle-5 start is never executed, and a fresh start is accepted at cycle 11.
- assert `rst` mid-division, asynchronously to `clk` -> `busy`, `done`, `hi`, `lo` become 0 immediately, and no `done` follows after `rst` deasserts.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register owner: iterative shift-add multiply and restoring divide with clocked commit.
// Define MULDIV_DIV_EN to build the divider datapath and DIV state.
module hilo_muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [2:0]  OP_MTHI = 3'd6;
  localparam logic [2:0]  OP_MTLO = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUL    = 2'd1,
    S_DIV    = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] opb;
  logic [CW-1:0]    cnt;
  logic             sa, sb, acc_q, div_q;

  logic             accept, is_mul, is_div, sgn, last;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next, prod_fix, hilo_sum;
  logic             busy_nxt, done_nxt;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;

  assign is_mul = !op[2];
  assign is_div = op[2] && !op[1];
  assign sgn    = !op[0] && !(op[2] && op[1]);
  assign accept = (state == S_IDLE) && start && !flush;
  assign last   = (cnt == CW'(WIDTH - 1));
  assign a_abs  = (sgn && A[WIDTH-1]) ? -A : A;
  assign b_abs  = (sgn && B[WIDTH-1]) ? -B : B;

  // Shift-add step: low half holds the unconsumed multiplier bits.
  assign mul_sum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign prod_fix = (sa ^ sb) ? -acc : acc;
  assign hilo_sum = {hi, lo} + prod_fix;

`ifdef MULDIV_DIV_EN
  logic             dbz_q, dbz_nxt, div_ge;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_diff, quo, rem;
  logic [W2-1:0]    div_next;

  // Restoring step: acc = {remainder, dividend/quotient}.
  assign div_sh   = {acc[W2-1:WIDTH], acc[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, opb});
  assign div_diff = div_sh[WIDTH-1:0] - opb;
  assign div_next = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
  assign quo      = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem      = sa ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
`else
  assign div_by_zero = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef MULDIV_DIV_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
`ifdef MULDIV_DIV_EN
      div_by_zero <= dbz_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && is_mul) state_nxt = S_MUL;
`ifdef MULDIV_DIV_EN
        else if (accept && is_div) state_nxt = (B == '0) ? S_COMMIT : S_DIV;
`endif
      end
      S_MUL: begin
        if (flush)     state_nxt = S_IDLE;
        else if (last) state_nxt = S_COMMIT;
      end
`ifdef MULDIV_DIV_EN
      S_DIV: begin
        if (flush)     state_nxt = S_IDLE;
        else if (last) state_nxt = S_COMMIT;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs; a flush in COMMIT drops the write.
  always_comb begin
    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = 1'b0;
    hi_nxt   = hi;
    lo_nxt   = lo;
`ifdef MULDIV_DIV_EN
    dbz_nxt  = 1'b0;
`endif
    if (accept && state_nxt == S_IDLE) begin
      done_nxt = 1'b1;
      if (op == OP_MTHI) hi_nxt = A;
      if (op == OP_MTLO) lo_nxt = A;
    end else if (state == S_COMMIT && !flush) begin
      done_nxt = 1'b1;
      if (!div_q) begin
        if (acc_q) {hi_nxt, lo_nxt} = hilo_sum;
        else       {hi_nxt, lo_nxt} = prod_fix;
      end
`ifdef MULDIV_DIV_EN
      else if (dbz_q) begin
        dbz_nxt = 1'b1;
      end else begin
        lo_nxt = quo;
        hi_nxt = rem;
      end
`endif
    end
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      opb   <= '0;
      cnt   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      acc_q <= 1'b0;
      div_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      dbz_q <= 1'b0;
`endif
    end else if (accept) begin
      acc   <= {{WIDTH{1'b0}}, a_abs};
      opb   <= b_abs;
      cnt   <= '0;
      sa    <= sgn && A[WIDTH-1];
      sb    <= sgn && B[WIDTH-1];
      acc_q <= !op[2] && op[1];
      div_q <= is_div;
`ifdef MULDIV_DIV_EN
      dbz_q <= is_div && (B == '0);
`endif
    end else if (state == S_MUL) begin
      acc <= mul_next;
      cnt <= cnt + CW'(1);
    end
`ifdef MULDIV_DIV_EN
    else if (state == S_DIV) begin
      acc <= div_next;
      cnt <= cnt + CW'(1);
    end
`endif
  end

endmodule
